// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants, state encoding and helpers for the pipeline controller
package pipe_ctrl_pkg;
    localparam logic        Stop       = 1'b1;
    localparam logic        NoStop     = 1'b0;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0040;
    localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
    localparam logic [5:0]  STALL_NONE = {6{NoStop}};
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MC_BUSY     = 2'd1,
        FLUSH_GUARD = 2'd2
    } state_t;

    // A request of zero cycles still costs one stall cycle, so the counter loads max(n,1)-1
    function automatic logic [5:0] mc_load(input logic [5:0] cycles);
        return (cycles == 6'd0) ? 6'd0 : cycles - 6'd1;
    endfunction
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for hazards, multi-cycle EX ops and exceptions
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_mc_req,
    input  logic [5:0]  ex_mc_cycles,
    input  logic [31:0] excptype_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        ex_mc_done
);
    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        exc;

    // Exceptions are honoured everywhere except the guard cycle that follows a flush
    assign exc = (excptype_i != 32'd0) && (state != FLUSH_GUARD);

    // State and countdown registers; reset aborts any multi-cycle op in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and counter: exception wins, then multi-cycle start/countdown
    always_comb begin
        state_nxt = exc                  ? FLUSH_GUARD :
                    (state == IDLE)      ? (ex_mc_req ? MC_BUSY : IDLE) :
                    (state == MC_BUSY)   ? ((cnt != 6'd0) ? MC_BUSY : IDLE) :
                                           IDLE;
        cnt_nxt   = exc                               ? 6'd0 :
                    (state == IDLE && ex_mc_req)      ? mc_load(ex_mc_cycles) :
                    (state == MC_BUSY && cnt != 6'd0) ? cnt - 6'd1 :
                                                        cnt;
    end

    // Outputs: everything held quiet while reset is asserted, regardless of inputs
    always_comb begin
        flush      = rst && exc;
        new_pc     = !flush ? 32'd0 : (excptype_i == EXC_ERET) ? epc_i : EXC_VECTOR;
        ex_mc_done = rst && !exc && (state == MC_BUSY) && (cnt == 6'd0);
        stall      = (!rst || exc)        ? STALL_NONE :
                     (state == IDLE)      ? (ex_mc_req ? STALL_EX : stallreq_id ? STALL_ID : STALL_NONE) :
                     (state == MC_BUSY)   ? ((cnt != 6'd0) ? STALL_EX : STALL_NONE) :
                                            STALL_NONE;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        ex_mc_req = 1'b0;
    logic [5:0]  ex_mc_cycles = 6'd0;
    logic [31:0] excptype_i = 32'd0;
    logic [31:0] epc_i = 32'd0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_done;
    int          checks = 0;
    int          errors = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
        .ex_mc_cycles(ex_mc_cycles), .excptype_i(excptype_i), .epc_i(epc_i),
        .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_done(ex_mc_done)
    );

    always #5 clk = ~clk;

    // Compares {stall, flush, done, new_pc} against the hand-computed vector
    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got stall=%b flush=%b done=%b pc=%h, want stall=%b flush=%b done=%b pc=%h",
                     tag, got[39:34], got[33], got[32], got[31:0], exp[39:34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [39:0] outv();
        return {stall, flush, ex_mc_done, new_pc};
    endfunction

    // Apply one cycle of inputs at the falling edge and settle before checking
    task automatic drive(input logic sid, input logic req, input logic [5:0] cyc,
                         input logic [31:0] exc, input logic [31:0] epc);
        @(negedge clk);
        stallreq_id  = sid;
        ex_mc_req    = req;
        ex_mc_cycles = cyc;
        excptype_i   = exc;
        epc_i        = epc;
        #1;
    endtask

    localparam logic [39:0] Q    = 40'd0;
    localparam logic [39:0] S_ID = {6'b000111, 1'b0, 1'b0, 32'd0};
    localparam logic [39:0] S_EX = {6'b001111, 1'b0, 1'b0, 32'd0};
    localparam logic [39:0] DONE = {6'b000000, 1'b0, 1'b1, 32'd0};
    localparam logic [39:0] FL40 = {6'b000000, 1'b1, 1'b0, 32'h0000_0040};
    localparam logic [39:0] FLRT = {6'b000000, 1'b1, 1'b0, 32'h0000_1234};

    initial begin
        stallreq_id = 1'b1; ex_mc_req = 1'b1; ex_mc_cycles = 6'd5; excptype_i = 32'h1; epc_i = 32'h99;
        #12;
        chk("reset_quiet", outv(), Q);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("idle_after_reset", outv(), Q);

        drive(1, 0, 0, 0, 0);  chk("id_stall_1", outv(), S_ID);
        drive(1, 0, 0, 0, 0);  chk("id_stall_2", outv(), S_ID);
        drive(0, 0, 0, 0, 0);  chk("id_release", outv(), Q);

        drive(0, 1, 4, 0, 0);  chk("mc4_c1", outv(), S_EX);
        drive(1, 1, 9, 0, 0);  chk("mc4_c2", outv(), S_EX);
        drive(1, 1, 9, 0, 0);  chk("mc4_c3", outv(), S_EX);
        drive(0, 0, 0, 0, 0);  chk("mc4_c4", outv(), S_EX);
        drive(0, 1, 3, 0, 0);  chk("mc4_done", outv(), DONE);
        drive(0, 0, 0, 0, 0);  chk("mc4_idle", outv(), Q);

        drive(0, 1, 0, 0, 0);  chk("mc0_stall", outv(), S_EX);
        drive(0, 0, 0, 0, 0);  chk("mc0_done", outv(), DONE);
        drive(0, 1, 1, 0, 0);  chk("mc1_stall", outv(), S_EX);
        drive(0, 0, 0, 0, 0);  chk("mc1_done", outv(), DONE);
        drive(0, 0, 0, 0, 0);  chk("mc1_idle", outv(), Q);

        drive(0, 1, 6, 0, 0);  chk("exc_mc_c1", outv(), S_EX);
        drive(0, 0, 0, 1, 0);  chk("exc_mc_flush", outv(), FL40);
        drive(0, 0, 0, 1, 0);  chk("exc_guard", outv(), Q);
        drive(0, 0, 0, 0, 0);  chk("exc_idle", outv(), Q);
        drive(0, 0, 0, 0, 0);  chk("exc_no_done", outv(), Q);

        drive(1, 1, 3, 32'he, 32'h1234);  chk("eret_flush", outv(), FLRT);
        drive(1, 1, 3, 32'he, 32'h1234);  chk("eret_guard", outv(), Q);
        drive(0, 0, 0, 0, 0);             chk("eret_idle", outv(), Q);

        drive(0, 1, 6, 0, 0);  chk("rst_mc_c1", outv(), S_EX);
        drive(0, 0, 0, 0, 0);  chk("rst_mc_c2", outv(), S_EX);
        #2 rst = 1'b0;
        #1 chk("rst_mid_quiet", outv(), Q);
        @(posedge clk);
        #2 chk("rst_held_quiet", outv(), Q);
        #1 rst = 1'b1;
        #1 chk("rst_release_idle", outv(), Q);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0);
            chk("rst_no_done", outv(), Q);
        end
        drive(1, 0, 0, 0, 0);  chk("rst_idle_id", outv(), S_ID);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
